pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised chain of NUM_STAGES pipeline buffers carrying a data word and a control word per stage, each stage with its own valid bit.
- Replaces the hand-instanced, globally-enabled inter-stage buffers of the core pipeline.
- Adds per-stage hold with automatic bubble insertion, per-stage flush and a bubble counter, on top of the existing global stall from multicycle units such as the FPU.

Parameters:
- DATA_WIDTH, 64, width of each stage's data word.
- CTRL_WIDTH, 8, width of each stage's control word.
- NUM_STAGES, 4, number of buffer stages (>=2). Stage 0 is youngest, stage NUM_STAGES-1 is oldest.
- RESET_CTRL, 0, control word loaded on reset, flush and bubble (a NOP encoding: no writes, no start).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset.
- in_valid  in  1  input word valid.
- in_data  in  DATA_WIDTH  input data word.
- in_ctrl  in  CTRL_WIDTH  input control word.
- in_stall  in  1  global stall; freezes every stage.
- in_hold_mask  in  NUM_STAGES  bit k holds stage k (e.g. load-use hazard).
- in_flush_mask  in  NUM_STAGES  bit k invalidates stage k (e.g. branch mispredict).
- out_ready  out  1  input accepted this cycle.
- out_valid  out  NUM_STAGES  per-stage valid bits.
- out_data  out  NUM_STAGES*DATA_WIDTH  stage k at [k*DATA_WIDTH +: DATA_WIDTH].
- out_ctrl  out  NUM_STAGES*CTRL_WIDTH  stage k at [k*CTRL_WIDTH +: CTRL_WIDTH].
- out_bubble_cnt  out  16  saturating count of cycles in which a bubble was inserted.

Interface decisions: one clock, Clk. Reset is Rst: synchronous, active-high.

Behaviour:
- All outputs are registered except out_ready, which is combinational.
- Reset, with Rst=1 at the edge, overrides everything:
  - out_valid = 0, all data = 0, all ctrl = RESET_CTRL, out_bubble_cnt = 0.
  - Applies regardless of stall, hold or flush.
- Freeze term: freeze[i] = in_stall | OR(in_hold_mask[NUM_STAGES-1:i]). A hold at stage k therefore freezes stages 0..k.
- out_ready = !freeze[0]. When out_ready=0, the input is not captured and upstream keeps presenting the word.
- Per-stage update, highest priority first:
  1. Rst: reset values as above.
  2. in_flush_mask[i]: valid <= 0, ctrl <= RESET_CTRL, data retained. Flush overrides stall and hold.
  3. freeze[i]: valid, data and ctrl retained.
  4. i>0 and freeze[i-1] (bubble): valid <= 0, ctrl <= RESET_CTRL, data retained.
  5. Otherwise advance. Stage 0 loads in_valid, in_data, in_ctrl; stage i loads stage i-1.
- Under in_stall, freeze[i-1] and freeze[i] are both true, so a global stall never inserts a bubble.
- Latency: a word accepted at edge t sits in stage i after edge t+i, extended by one cycle per freeze of that stage.
- Invalid words (in_valid=0) advance like valid ones, carrying ctrl as supplied.
- Flushing stage 0 while out_ready=1 drops the input word that cycle; out_ready still reads 1.
- Hold and flush on the same stage: the stage is invalidated; stages below it stay frozen.
- out_bubble_cnt increments by 1 in any cycle where at least one stage takes the bubble path. It counts by cycles, not by stages.
  - Saturates at 16'hFFFF.
  - A stage that takes the bubble path counts even if its previous content was already invalid.
  - Not incremented on reset.
- Clearing a hold resumes normal advance the next cycle; there is no recovery delay.

Test Plan:
1. NUM_STAGES=4. Rst for 2 cycles, then feed valid data 1,2,3,4 on consecutive cycles.
   -> out_valid=0000 and ctrl=RESET_CTRL during reset; stage 3 data=1 three edges after first acceptance; out_valid=1111 after the fourth feed.
2. With stages 0..3 = D,C,B,A, drive in_stall=1 for 2 cycles.
   -> All stages unchanged; out_ready=0; out_bubble_cnt=0; stream resumes in order afterwards.
3. Same fill, in_hold_mask=0010 for one cycle.
   -> Next: stage0=D, stage1=C, stage2 valid=0 with ctrl=RESET_CTRL, stage3=B; out_ready=0 during the hold; out_bubble_cnt=1.
4. in_stall=1 with in_flush_mask=0011.
   -> Stages 0,1 valid=0 with ctrl=RESET_CTRL; stages 2,3 unchanged; no counter change.
5. Hold stage 0 continuously for 65,540 cycles with stage 1 bubbling.
   -> out_bubble_cnt reaches 16'hFFFF and stays there; a following Rst returns it to 0.
6. Assert Rst in the same cycle as in_stall=1, in_hold_mask=1111 and in_valid=1.
   -> Next cycle: out_valid=0000, all data=0, ctrl=RESET_CTRL, out_bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Chain of NUM_STAGES data/ctrl buffers with a global stall, per-stage hold
// (a bubble is inserted just above the highest held stage), per-stage flush and a bubble counter.

module pipe_stage_chain_stage #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CTRL_WIDTH = 8,
    parameter logic [CTRL_WIDTH-1:0] RESET_CTRL = '0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  bubble,
    input  logic                  prev_valid,
    input  logic [DATA_WIDTH-1:0] prev_data,
    input  logic [CTRL_WIDTH-1:0] prev_ctrl,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CTRL_WIDTH-1:0] ctrl
);

    // Flush and bubble both keep the data word; only valid and ctrl are scrubbed.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= RESET_CTRL;
        end else if (flush || (!freeze && bubble)) begin
            valid <= 1'b0;
            ctrl  <= RESET_CTRL;
        end else if (!freeze) begin
            valid <= prev_valid;
            data  <= prev_data;
            ctrl  <= prev_ctrl;
        end
    end

endmodule

module pipe_stage_chain #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CTRL_WIDTH = 8,
    parameter int                    NUM_STAGES = 4,
    parameter logic [CTRL_WIDTH-1:0] RESET_CTRL = '0
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_stall,
    input  logic [NUM_STAGES-1:0]            in_hold_mask,
    input  logic [NUM_STAGES-1:0]            in_flush_mask,
    output logic                             out_ready,
    output logic [NUM_STAGES-1:0]            out_valid,
    output logic [NUM_STAGES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_STAGES*CTRL_WIDTH-1:0] out_ctrl,
    output logic [15:0]                      out_bubble_cnt
);

    logic [NUM_STAGES-1:0]                 freeze;
    logic [NUM_STAGES-1:0]                 bubble;
    logic [NUM_STAGES-1:0]                 bubble_taken;
    logic [NUM_STAGES-1:0]                 vld_pipe;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] data_q;
    logic [NUM_STAGES-1:0][CTRL_WIDTH-1:0] ctrl_q;
    logic [NUM_STAGES-1:0]                 prev_valid;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] prev_data;
    logic [NUM_STAGES-1:0][CTRL_WIDTH-1:0] prev_ctrl;
    logic [15:0]                           bubble_cnt;

    // A hold at stage k freezes everything younger, so freeze is a suffix-OR from the oldest stage down.
    always_comb begin
        freeze = '0;
        freeze[NUM_STAGES-1] = in_stall | in_hold_mask[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            freeze[i] = freeze[i+1] | in_hold_mask[i];
        end
    end

    assign bubble       = {freeze[NUM_STAGES-2:0], 1'b0};
    assign bubble_taken = bubble & ~freeze & ~in_flush_mask;
    assign out_ready    = ~freeze[0];

    assign prev_valid[0] = in_valid;
    assign prev_data[0]  = in_data;
    assign prev_ctrl[0]  = in_ctrl;

    for (genvar i = 1; i < NUM_STAGES; i++) begin : g_link
        assign prev_valid[i] = vld_pipe[i-1];
        assign prev_data[i]  = data_q[i-1];
        assign prev_ctrl[i]  = ctrl_q[i-1];
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        pipe_stage_chain_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .CTRL_WIDTH (CTRL_WIDTH),
            .RESET_CTRL (RESET_CTRL)
        ) u_stage (
            .Clk        (Clk),
            .Rst        (Rst),
            .flush      (in_flush_mask[i]),
            .freeze     (freeze[i]),
            .bubble     (bubble[i]),
            .prev_valid (prev_valid[i]),
            .prev_data  (prev_data[i]),
            .prev_ctrl  (prev_ctrl[i]),
            .valid      (vld_pipe[i]),
            .data       (data_q[i]),
            .ctrl       (ctrl_q[i])
        );
    end

    // Counts cycles with any bubble, not the number of bubbled stages.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bubble_cnt <= '0;
        end else if ((|bubble_taken) && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign out_valid      = vld_pipe;
    assign out_data       = data_q;
    assign out_ctrl       = ctrl_q;
    assign out_bubble_cnt = bubble_cnt;

endmodule
